divider_nonrestoring: RTL and testbench

- Sequential sign-magnitude integer divider using the non-restoring (add/subtract alternating) method.
- Sits directly downstream of the divisor complement stage. It consumes [|y|]two's-comp and [-|y|]two's-comp plus the divisor sign bit.
- Produces a sign-magnitude quotient and remainder, one quotient bit per clock.
- Handshake is start/busy/done.

---
 rtl/divider_nonrestoring.sv | 146 ++++++++++++++
 tb/tb_divider_nonrestoring.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/divider_nonrestoring.sv
// Sequential sign-magnitude non-restoring divider that produces one quotient bit per clock.
// Define NEG_ZERO_CLEAR_EN to force the sign bit to 0 on any zero-magnitude result.
module divider_nonrestoring #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic         divisor_sign,
  input  logic [N-1:0] divisor_abs,
  input  logic [N-1:0] divisor_minus,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int M     = N - 1;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX, FINISH} state_t;

  state_t             state_q, state_n;
  logic [N-1:0]       x_q, x_n;
  logic               ysign_q, ysign_n;
  logic [N-1:0]       yabs_q, yabs_n;
  logic [N-1:0]       yminus_q, yminus_n;
  logic [N:0]         r_q, r_n;
  logic [M-1:0]       q_q, q_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               busy_n, done_n, dz_n;
  logic [N-1:0]       quot_n, rem_n;

  logic [N:0]         shifted, addend, r_new;
  logic [M-1:0]       r_fix;

  function automatic logic [N-1:0] sign_fix(input logic [N-1:0] v);
`ifdef NEG_ZERO_CLEAR_EN
    if (v[M-1:0] == '0) return '0;
    return v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    ysign_n  = ysign_q;
    yabs_n   = yabs_q;
    yminus_n = yminus_q;
    r_n      = r_q;
    q_n      = q_q;
    cnt_n    = cnt_q;
    busy_n   = busy;
    done_n   = done;
    dz_n     = div_by_zero;
    quot_n   = quotient;
    rem_n    = remainder;
    shifted  = '0;
    addend   = '0;
    r_new    = '0;
    r_fix    = '0;

    case (state_q)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          x_n      = dividend;
          ysign_n  = divisor_sign;
          yabs_n   = divisor_abs;
          yminus_n = divisor_minus;
          busy_n   = 1'b1;
          dz_n     = 1'b0;
          r_n      = '0;
          q_n      = dividend[M-1:0];
          cnt_n    = '0;
          state_n  = (divisor_abs[M-1:0] == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        // Sign of the pre-shift remainder picks subtract (non-negative) or add (negative).
        shifted = {r_q[N-1:0], q_q[M-1]};
        addend  = r_q[N] ? {yabs_q[N-1], yabs_q} : {yminus_q[N-1], yminus_q};
        r_new   = shifted + addend;
        r_n     = r_new;
        q_n     = {q_q[M-2:0], ~r_new[N]};
        cnt_n   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(M - 1)) state_n = FIX;
      end
      FIX: begin
        // Only the magnitude bits of the corrected remainder are kept.
        r_fix   = r_q[M-1:0] + (r_q[N] ? yabs_q[M-1:0] : '0);
        quot_n  = sign_fix({x_q[N-1] ^ ysign_q, q_q});
        rem_n   = sign_fix({x_q[N-1], r_fix});
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      FINISH: begin
        quot_n  = sign_fix({x_q[N-1] ^ ysign_q, {M{1'b1}}});
        rem_n   = sign_fix(x_q);
        dz_n    = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      ysign_q     <= 1'b0;
      yabs_q      <= '0;
      yminus_q    <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state_q     <= state_n;
      x_q         <= x_n;
      ysign_q     <= ysign_n;
      yabs_q      <= yabs_n;
      yminus_q    <= yminus_n;
      r_q         <= r_n;
      q_q         <= q_n;
      cnt_q       <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dz_n;
      quotient    <= quot_n;
      remainder   <= rem_n;
    end
  end

endmodule

// File: tb/tb_divider_nonrestoring.sv
// Scoreboarded directed bench for divider_nonrestoring: expected results come from a
// behavioural sign-magnitude model using / and % on the magnitudes.
module tb_divider_nonrestoring;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic       divisor_sign;
  logic [7:0] divisor_abs;
  logic [7:0] divisor_minus;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  divider_nonrestoring #(.N(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dividend     (dividend),
    .divisor_sign (divisor_sign),
    .divisor_abs  (divisor_abs),
    .divisor_minus(divisor_minus),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int unsigned xm = int'(x[6:0]);
    int unsigned ym = int'(y[6:0]);
    if (ym == 0) begin
      e.q  = {x[7] ^ y[7], 7'h7F};
      e.r  = x;
      e.dz = 1'b1;
    end else begin
      e.q  = {x[7] ^ y[7], 7'(xm / ym)};
      e.r  = {x[7], 7'(xm % ym)};
      e.dz = 1'b0;
    end
`ifdef NEG_ZERO_CLEAR_EN
    if (e.q[6:0] == 7'h00) e.q[7] = 1'b0;
    if (e.r[6:0] == 7'h00) e.r[7] = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a;
    a             = {1'b0, y[6:0]};
    dividend      = x;
    divisor_sign  = y[7];
    divisor_abs   = a;
    divisor_minus = -a;
  endtask

  // Starts from a point away from the clock edge; returns #1 after the done edge.
  task automatic run_div(input logic [7:0] x, input logic [7:0] y, input bit disturb);
    exp_t e;
    int   cyc;
    int   exp_lat;
    sb.push_back(model(x, y));
    exp_lat = (y[6:0] == 7'h00) ? 1 : 8;
    drive(x, y);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    chk("dz_cleared_on_accept", 32'(div_by_zero), 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc >= 3 && cyc <= 5) begin
        start = 1'b1;
        drive(~x, 8'h81);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e      = sb.pop_front();
      last_e = e;
      chk("quotient", 32'(quotient), 32'(e.q));
      chk("remainder", 32'(remainder), 32'(e.r));
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  task automatic idle_watch(input int n, input logic [7:0] exp_q, input logic [7:0] exp_r);
    int dones = 0;
    int busies = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busies++;
    end
    chk("no_extra_done", 32'(dones), 32'd0);
    chk("no_extra_busy", 32'(busies), 32'd0);
    chk("quotient_held", 32'(quotient), 32'(exp_q));
    chk("remainder_held", 32'(remainder), 32'(exp_r));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div(8'h64, 8'h07, 1'b0);
    run_div(8'hE4, 8'h07, 1'b0);
    run_div(8'h7F, 8'h81, 1'b0);
    run_div(8'h05, 8'h09, 1'b0);
    run_div(8'h7F, 8'h7F, 1'b0);
    run_div(8'h85, 8'h80, 1'b0);
    run_div(8'h80, 8'h03, 1'b0);
    run_div(8'h80, 8'h00, 1'b0);
    run_div(8'h3C, 8'h85, 1'b0);
    run_div(8'h01, 8'h01, 1'b0);

    run_div(8'h64, 8'h07, 1'b1);
    idle_watch(10, last_e.q, last_e.r);

    drive(8'h7F, 8'h03);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_watch(12, 8'h00, 8'h00);

    run_div(8'h30, 8'h05, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
